// File: rtl/regfile_seq_pkg.sv
// Shared types for the register-file sequencer: opcode and FSM encodings plus instruction field layout.
// Consumed by regfile_seq and regfile_seq_alu.
package regfile_seq_pkg;

    localparam int DATA_W  = 8;
    localparam int SEL_W   = 2;
    localparam int INSTR_W = 16;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 10;
    localparam int RS_HI   = 9;
    localparam int RS_LO   = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LI  = 4'd1,
        OP_MOV = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_NOT = 4'd8
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Opcodes 1..8 produce a register result; everything else skips EXEC.
    function automatic logic writes_rf(input logic [3:0] op);
        return (op >= OP_LI) && (op <= OP_NOT);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_NOT;
    endfunction

    function automatic logic sets_flags(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational 8-bit ALU for the sequencer; carry is ADD carry-out or SUB borrow, zero otherwise.
module regfile_seq_alu
    import regfile_seq_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_LI:   result = imm;
            OP_MOV:  result = b;
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_seq.sv
// Instruction sequencer driving an external 4x8 register file: IDLE -> READ -> EXEC -> WB.
// Optional zero/carry flag outputs are built when REGFILE_SEQ_FLAGS_EN is defined.
module regfile_seq
    import regfile_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic              rf_write_en,
    output logic [1:0]        rf_write_sel,
    output logic [7:0]        rf_input_data,
    output logic [1:0]        rf_port_a_sel,
    output logic [1:0]        rf_port_b_sel,
    input  logic [7:0]        rf_port_a_data,
    input  logic [7:0]        rf_port_b_data,
    output logic              done,
    output logic              err,
    output logic              busy
`ifdef REGFILE_SEQ_FLAGS_EN
    ,
    output logic              zero_flag,
    output logic              carry_flag
`endif
);

    state_e            state_q, state_d;
    logic              accept;

    logic [3:0]        opcode_q, opcode_d;
    logic [SEL_W-1:0]  rd_q, rd_d;
    logic [SEL_W-1:0]  rs_q, rs_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [SEL_W-1:0]  port_a_sel_q, port_a_sel_d;
    logic [SEL_W-1:0]  port_b_sel_q, port_b_sel_d;

    logic [DATA_W-1:0] alu_result;

    assign accept = instr_valid && (state_q == ST_IDLE);

`ifdef REGFILE_SEQ_FLAGS_EN
    logic alu_carry;
`else
    logic unused_alu_carry;
`endif

    regfile_seq_alu u_alu (
        .op     (opcode_q),
        .a      (op_a_q),
        .b      (op_b_q),
        .imm    (imm_q),
        .result (alu_result),
`ifdef REGFILE_SEQ_FLAGS_EN
        .carry  (alu_carry)
`else
        .carry  (unused_alu_carry)
`endif
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_valid) state_d = ST_READ;
            ST_READ: state_d = writes_rf(opcode_q) ? ST_EXEC : ST_WB;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        instr_ready   = (state_q == ST_IDLE);
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_WB);
        err           = (state_q == ST_WB) && is_illegal(opcode_q);
        // Gating with reset keeps an instruction reset during WB from landing in the file.
        rf_write_en   = (state_q == ST_WB) && writes_rf(opcode_q) && !reset;
        rf_write_sel  = (state_q == ST_WB) ? rd_q : '0;
        rf_input_data = (state_q == ST_WB) ? result_q : '0;
        rf_port_a_sel = (state_q == ST_READ) ? rd_q : port_a_sel_q;
        rf_port_b_sel = (state_q == ST_READ) ? rs_q : port_b_sel_q;
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        opcode_d     = opcode_q;
        rd_d         = rd_q;
        rs_d         = rs_q;
        imm_d        = imm_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        port_a_sel_d = port_a_sel_q;
        port_b_sel_d = port_b_sel_q;

        if (accept) begin
            opcode_d = instr[OPC_HI:OPC_LO];
            rd_d     = instr[RD_HI:RD_LO];
            rs_d     = instr[RS_HI:RS_LO];
            imm_d    = instr[IMM_HI:IMM_LO];
        end

        // Selectors remember the READ values so the file ports stay quiet afterwards.
        if (state_q == ST_READ) begin
            op_a_d       = rf_port_a_data;
            op_b_d       = rf_port_b_data;
            port_a_sel_d = rd_q;
            port_b_sel_d = rs_q;
        end

        if (state_q == ST_EXEC) begin
            result_d = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q     <= '0;
            rd_q         <= '0;
            rs_q         <= '0;
            imm_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            port_a_sel_q <= '0;
            port_b_sel_q <= '0;
        end else begin
            opcode_q     <= opcode_d;
            rd_q         <= rd_d;
            rs_q         <= rs_d;
            imm_q        <= imm_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            port_a_sel_q <= port_a_sel_d;
            port_b_sel_q <= port_b_sel_d;
        end
    end

`ifdef REGFILE_SEQ_FLAGS_EN
    // Carry is sampled with the result in EXEC; both flags commit as WB retires.
    logic carry_q, carry_d;
    logic zero_flag_q, zero_flag_d;
    logic carry_flag_q, carry_flag_d;

    always_comb begin
        carry_d      = carry_q;
        zero_flag_d  = zero_flag_q;
        carry_flag_d = carry_flag_q;
        if (state_q == ST_EXEC) begin
            carry_d = alu_carry;
        end
        if ((state_q == ST_WB) && sets_flags(opcode_q)) begin
            zero_flag_d  = (result_q == '0);
            carry_flag_d = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q      <= 1'b0;
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            carry_q      <= carry_d;
            zero_flag_q  <= zero_flag_d;
            carry_flag_q <= carry_flag_d;
        end
    end

    assign zero_flag  = zero_flag_q;
    assign carry_flag = carry_flag_q;
`endif

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: instr_valid  in  1  instruction offered; instr_ready  out  1  sequencer can accept; instr  in  16  [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-003 SHALL have ports: rf_write_en  out  1; rf_write_sel  out  2; rf_input_data  out  8; rf_port_a_sel  out  2; rf_port_b_sel  out  2 -- drive the 4x8 register file.
REQ-004 SHALL have ports: rf_port_a_data  in  8; rf_port_b_data  in  8 -- combinational read data from the register file.
REQ-005 SHALL have ports: done  out  1  instruction-complete pulse; err  out  1  illegal-opcode pulse; busy  out  1  high outside IDLE.

Function
REQ-006 SHALL accept an instruction only on a clk edge with instr_valid=1 and instr_ready=1; instr_ready SHALL be 1 exactly in IDLE.
REQ-007 SHALL register opcode, rd, rs, imm at acceptance; instr SHALL be ignored afterwards until the next acceptance.
REQ-008 SHALL implement states IDLE -> READ -> EXEC -> WB -> IDLE, one cycle each; NOP and illegal opcodes SHALL go IDLE -> READ -> WB.
REQ-009 In READ: rf_port_a_sel=rd, rf_port_b_sel=rs; operands SHALL be captured from rf_port_a_data/rf_port_b_data at the end of READ.
REQ-010 Outside READ, rf_port_a_sel and rf_port_b_sel SHALL hold their last values.
REQ-011 Opcodes: 0 NOP; 1 LI rd<=imm; 2 MOV rd<=rs; 3 ADD rd<=rd+rs; 4 SUB rd<=rd-rs; 5 AND; 6 OR; 7 XOR; 8 NOT rd<=~rs; 9-15 illegal.
REQ-012 Arithmetic SHALL be 8-bit modulo 256 (ADD FF+01=00; SUB 00-01=FF).
REQ-013 Result SHALL be registered at the end of EXEC.
REQ-014 In WB: rf_write_en=1, rf_write_sel=rd, rf_input_data=result for opcodes 1-8; rf_write_en=0 for NOP/illegal.
REQ-015 rf_write_en SHALL be 0 in every state other than WB.
REQ-016 done SHALL be 1 for exactly the WB cycle of every accepted instruction; err SHALL be 1 in the WB cycle of an illegal opcode only.
REQ-017 Latency: accept at edge N; register file updated at edge N+3; next acceptance no earlier than edge N+4.
REQ-018 rd==rs SHALL be legal (ADD R1,R1 doubles R1).

Reset
REQ-019 reset SHALL move the FSM to IDLE at the next edge, regardless of state, and discard any in-flight instruction without writing it.
REQ-020 Reset values: instr_ready=1, busy=0, done=0, err=0, rf_write_en=0, rf_write_sel=0, rf_input_data=00, rf_port_a_sel=0, rf_port_b_sel=0, internal operand and result registers 00.
REQ-021 reset SHALL take priority over instr_valid in the same cycle (no acceptance).

Configuration
REQ-022 Macro REGFILE_SEQ_FLAGS_EN defined: outputs zero_flag (1) and carry_flag (1) SHALL exist, reset to 0, and update at the end of WB for opcodes 3-8 only.
REQ-023 With REGFILE_SEQ_FLAGS_EN: zero_flag = (result==00); carry_flag = ADD carry-out, SUB borrow (rd<rs), and 0 for opcodes 5-8.
REQ-024 Without REGFILE_SEQ_FLAGS_EN: zero_flag and carry_flag ports and their logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-025 Package regfile_seq_pkg SHALL hold the opcode enum, the FSM state enum, and the instruction field bit positions.
REQ-026 Combinational ALU SHALL be the sub-module regfile_seq_alu (inputs op, a, b, imm; outputs result, carry); the FSM stays in regfile_seq.

Verification
REQ-027 Reset, then LI R0,AA; LI R1,BB -> rf_write_en pulses with sel 0 data AA, then sel 1 data BB; done twice; R0=AA, R1=BB.
REQ-028 R2=FF, R3=01, ADD R2,R3 -> R2=00; with flags: zero=1, carry=1; then SUB R3,R2 (01-00) -> R3=01, carry=0.
REQ-029 instr_valid held high continuously with 3 instructions -> acceptances exactly 4 cycles apart; instr_ready=0 for 3 cycles after each acceptance.
REQ-030 Opcode F -> no rf_write_en; done=1 and err=1 in the same single cycle; register contents unchanged.
REQ-031 Reset asserted in EXEC of LI R1,55 -> no write; R1 keeps its prior value; instr_ready=1 the cycle after reset.
REQ-032 reset and instr_valid high together -> no acceptance; busy stays 0.
